parser_rule_loader: RTL and testbench
=====================================

# parser_rule_loader

Configuration initiator for the pipelined packet parser. It accepts rule read/write commands from a host-side valid/ready stream and turns each one into a single-cycle strobe on the parser rule bus (`rule_wren`/`rule_rden`/`rule_addr`/`rule_wdata`). For reads, it waits for `rule_rdata_valid` with a bounded timeout. Every command returns exactly one response on a valid/ready stream, so software can program layer 0–3 type offsets, key offsets and shift values without knowing bus timing.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles to wait for read data after `o_rule_rden`; legal range 1..65535.
- `ERR_CNT_WIDTH`, default 16: width of the saturating timeout counter.

Ports:
- Clock and reset: one clock, `i_clk`; reset `i_rst` is synchronous and active-high.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_cmd_valid`  in  1  command present.
- `o_cmd_ready`  out  1  loader can accept a command.
- `i_cmd_write`  in  1  1 = write, 0 = read.
- `i_cmd_addr`  in  32  rule address; [25:24] selects the layer, [10:8] the rule class, low bits the index.
- `i_cmd_wdata`  in  32  write data; ignored for reads.
- `o_resp_valid`  out  1  response present.
- `i_resp_ready`  in  1  host accepts the response.
- `o_resp_data`  out  32  echoed write data, captured read data, or 0 on timeout.
- `o_resp_status`  out  2  00 write done, 01 read ok, 10 read timeout, 11 unused.
- `o_rule_wren`  out  1  one-cycle write strobe to the parser.
- `o_rule_rden`  out  1  one-cycle read strobe to the parser.
- `o_rule_addr`  out  32  rule address, registered.
- `o_rule_wdata`  out  32  rule write data, registered.
- `i_rule_rdata_valid`  in  1  read data valid from the parser.
- `i_rule_rdata`  in  32  read data from the parser.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_err_cnt`  out  `ERR_CNT_WIDTH`  count of read timeouts; saturates at all-ones.

## Operation
- FSM states: IDLE, WSTROBE, RSTROBE, RWAIT, RESP.
- IDLE
  - `o_cmd_ready` = 1; in every other state it is 0.
  - On `i_cmd_valid & o_cmd_ready`, capture addr, wdata and write.
  - Go to WSTROBE if write=1, otherwise RSTROBE.
- WSTROBE
  - `o_rule_wren` = 1 for this cycle only.
  - `o_rule_addr`/`o_rule_wdata` show the captured command.
  - Load resp_data = wdata and status = 00, then go to RESP.
- RSTROBE
  - `o_rule_rden` = 1 for this cycle only; `o_rule_wdata` keeps its last value.
  - Clear the wait counter and go to RWAIT.
- RWAIT
  - Each cycle, sample `i_rule_rdata_valid`.
  - If it is 1: load resp_data = `i_rule_rdata`, status = 01, go to RESP.
  - Otherwise increment the counter. If the counter reaches `TIMEOUT_CYCLES`: load resp_data = 0, status = 10, increment `o_err_cnt` (saturating), go to RESP.
  - If valid arrives on the same cycle the counter reaches the limit, valid wins and the result is status 01.
- RESP
  - `o_resp_valid` = 1; `o_resp_data`/`o_resp_status` are held stable until `i_resp_ready`.
  - On handshake, go to IDLE.
- `i_rule_rdata_valid` is ignored in any state other than RWAIT; late or stray data is discarded.
- `o_rule_addr`/`o_rule_wdata` hold their last driven values between strobes. The address is not decoded or range-checked; layer selection is the parser's job.
- At most one command is in flight, and there is never more than one strobe per command.

## Timing
- Reset values:
  - state IDLE
  - `o_cmd_ready` = 0 during the reset cycle, 1 from the first cycle after reset
  - `o_resp_valid`, `o_rule_wren`, `o_rule_rden`, `o_busy` = 0
  - `o_rule_addr`, `o_rule_wdata`, `o_resp_data`, `o_resp_status`, `o_err_cnt` = 0
- Write, with the command accepted at cycle T: `o_rule_wren` high at T+1, `o_resp_valid` high at T+2. With `i_resp_ready` held high, `o_cmd_ready` is high again at T+3.
- Read, accepted at T: `o_rule_rden` high at T+1. Valid is sampled from T+2.
  - If valid is seen at cycle V, `o_resp_valid` is high at V+1.
  - On timeout, `o_resp_valid` is high at T+2+`TIMEOUT_CYCLES`.
- All outputs are registered; there are no combinational paths from input to output.
- `i_rst` asserted in any state: the next state is IDLE, any pending response is dropped, and no strobe is issued in the following cycle. `o_err_cnt` clears.
- Back-to-back commands are supported. The minimum spacing between write strobes is 3 cycles.

## Test plan
- Write `addr=0x0000_0402`, `wdata=0x0000_0011`: a single `o_rule_wren` pulse at T+1 with `o_rule_addr=0x0000_0402` and `o_rule_wdata=0x11`; a response at T+2 with status 00 and data 0x11.
- Read `addr=0x0200_0300`, with the bench returning valid and `rdata=0xDEAD_BEEF` 5 cycles after rden: response status 01, data 0xDEADBEEF, exactly one rden pulse.
- Read with no data and `TIMEOUT_CYCLES=8`: response status 10, data 0, arriving 10 cycles after acceptance; `o_err_cnt`=1. A stray valid presented afterwards does not change state.
- Hold `i_resp_ready`=0 for 20 cycles after a write: the response stays stable, `o_cmd_ready` stays 0, and a second `i_cmd_valid` is not accepted until the handshake.
- Assert `i_rst` during RWAIT: next cycle state is IDLE with `o_resp_valid`, `o_rule_rden`=0 and `o_err_cnt`=0; the following write behaves normally.
- Four back-to-back writes to layers 0–3 with ready always high: four wren pulses spaced 3 cycles apart, with the addresses in order.

Source files
------------

// File: rtl/parser_rule_loader.sv
// parser_rule_loader
// Turns host rule read/write commands into single-cycle strobes on the parser
// rule bus and returns exactly one response per command. Reads wait for
// i_rule_rdata_valid with a bounded timeout; timeouts are counted.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready   command stream (write flag, 32b address, 32b data)
//   o_resp_*/i_resp_ready response stream (32b data, 2b status)
//   o_rule_wren/rden      one-cycle strobes to the parser
//   o_rule_addr/wdata     registered rule bus address/data, held between strobes
//   i_rule_rdata_valid/i_rule_rdata  read return from the parser
//   o_busy                not idle
//   o_err_cnt             saturating count of read timeouts
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | ready for a command
// WSTROBE | write strobe on the rule bus
// RSTROBE | read strobe on the rule bus, arm the timeout
// RWAIT   | waiting for read data or timeout
// RESP    | response presented, waiting for host handshake

module parser_rule_loader #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [31:0]              i_cmd_addr,
  input  logic [31:0]              i_cmd_wdata,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output logic [31:0]              o_resp_data,
  output logic [1:0]               o_resp_status,
  output logic                     o_rule_wren,
  output logic                     o_rule_rden,
  output logic [31:0]              o_rule_addr,
  output logic [31:0]              o_rule_wdata,
  input  logic                     i_rule_rdata_valid,
  input  logic [31:0]              i_rule_rdata,
  output logic                     o_busy,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

  localparam logic [1:0] ST_WR_DONE = 2'b00;
  localparam logic [1:0] ST_RD_OK   = 2'b01;
  localparam logic [1:0] ST_RD_TO   = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WSTROBE = 3'd1,
    RSTROBE = 3'd2,
    RWAIT   = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [15:0]              wt_cnt, wt_cnt_nxt;
  logic [31:0]              resp_data_nxt;
  logic [1:0]               resp_status_nxt;
  logic [31:0]              rule_addr_nxt;
  logic [31:0]              rule_wdata_nxt;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_nxt;

  always_comb begin
    state_nxt       = state;
    wt_cnt_nxt      = wt_cnt;
    resp_data_nxt   = o_resp_data;
    resp_status_nxt = o_resp_status;
    rule_addr_nxt   = o_rule_addr;
    rule_wdata_nxt  = o_rule_wdata;
    err_cnt_nxt     = o_err_cnt;
    case (state)
      IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          rule_addr_nxt = i_cmd_addr;
          if (i_cmd_write) begin
            rule_wdata_nxt = i_cmd_wdata;
            state_nxt      = WSTROBE;
          end else begin
            state_nxt = RSTROBE;
          end
        end
      end
      WSTROBE: begin
        // o_rule_wdata already holds the captured write data
        resp_data_nxt   = o_rule_wdata;
        resp_status_nxt = ST_WR_DONE;
        state_nxt       = RESP;
      end
      RSTROBE: begin
        // down-counter: terminal count 1 marks the last RWAIT cycle
        wt_cnt_nxt = 16'(TIMEOUT_CYCLES);
        state_nxt  = RWAIT;
      end
      RWAIT: begin
        if (i_rule_rdata_valid) begin
          // data wins even on the terminal-count cycle
          resp_data_nxt   = i_rule_rdata;
          resp_status_nxt = ST_RD_OK;
          state_nxt       = RESP;
        end else if (wt_cnt == 16'd1) begin
          resp_data_nxt   = 32'd0;
          resp_status_nxt = ST_RD_TO;
          if (!(&o_err_cnt)) begin
            err_cnt_nxt = o_err_cnt + ERR_CNT_WIDTH'(1);
          end
          state_nxt = RESP;
        end else begin
          wt_cnt_nxt = wt_cnt - 16'd1;
        end
      end
      RESP: begin
        if (i_resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so each strobe/flag
  // lines up with the state it belongs to without any input-to-output path.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      wt_cnt        <= 16'd0;
      o_cmd_ready   <= 1'b0;
      o_resp_valid  <= 1'b0;
      o_rule_wren   <= 1'b0;
      o_rule_rden   <= 1'b0;
      o_busy        <= 1'b0;
      o_rule_addr   <= 32'd0;
      o_rule_wdata  <= 32'd0;
      o_resp_data   <= 32'd0;
      o_resp_status <= 2'b00;
      o_err_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      wt_cnt        <= wt_cnt_nxt;
      o_cmd_ready   <= (state_nxt == IDLE);
      o_resp_valid  <= (state_nxt == RESP);
      o_rule_wren   <= (state_nxt == WSTROBE);
      o_rule_rden   <= (state_nxt == RSTROBE);
      o_busy        <= (state_nxt != IDLE);
      o_rule_addr   <= rule_addr_nxt;
      o_rule_wdata  <= rule_wdata_nxt;
      o_resp_data   <= resp_data_nxt;
      o_resp_status <= resp_status_nxt;
      o_err_cnt     <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_parser_rule_loader.sv
module tb_parser_rule_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [31:0] i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_data;
  logic [1:0]  o_resp_status;
  logic        o_rule_wren;
  logic        o_rule_rden;
  logic [31:0] o_rule_addr;
  logic [31:0] o_rule_wdata;
  logic        i_rule_rdata_valid;
  logic [31:0] i_rule_rdata;
  logic        o_busy;
  logic [15:0] o_err_cnt;

  parser_rule_loader #(.TIMEOUT_CYCLES(8), .ERR_CNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_data(o_resp_data), .o_resp_status(o_resp_status),
    .o_rule_wren(o_rule_wren), .o_rule_rden(o_rule_rden),
    .o_rule_addr(o_rule_addr), .o_rule_wdata(o_rule_wdata),
    .i_rule_rdata_valid(i_rule_rdata_valid), .i_rule_rdata(i_rule_rdata),
    .o_busy(o_busy), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } strobe_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  status;
  } resp_t;

  strobe_t     strobe_q[$];
  resp_t       resp_q[$];
  int          wren_cyc[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] last_wdata = 32'd0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Scoreboard: strobes and responses are popped as the DUT produces them.
  always @(negedge i_clk) begin
    if (o_rule_wren || o_rule_rden) begin
      if (strobe_q.size() == 0) begin
        chk("strobe_expected", 32'(strobe_q.size()), 32'd1);
      end else begin
        strobe_t s;
        s = strobe_q.pop_front();
        chk("strobe_wren", o_rule_wren, s.wr);
        chk("strobe_rden", o_rule_rden, !s.wr);
        chk("strobe_addr", o_rule_addr, s.addr);
        chk("strobe_wdata", o_rule_wdata, s.wdata);
      end
      if (o_rule_wren) wren_cyc.push_back(cyc);
    end
    if (o_resp_valid && i_resp_ready) begin
      if (resp_q.size() == 0) begin
        chk("resp_expected", 32'(resp_q.size()), 32'd1);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("resp_data", o_resp_data, r.data);
        chk("resp_status", o_resp_status, r.status);
      end
    end
  end

  // Leaves the bench one cycle after acceptance (cycle T+1); t_acc = T.
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_resp, input logic [31:0] exp_data,
                          input logic [1:0] exp_status, output int t_acc);
    int n;
    strobe_t s;
    resp_t r;
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = wdata;
    n = 0;
    while (!o_cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", o_cmd_ready, 1'b1);
    if (wr) last_wdata = wdata;
    s.wr = wr; s.addr = addr; s.wdata = last_wdata;
    strobe_q.push_back(s);
    if (exp_resp) begin
      r.data = exp_data; r.status = exp_status;
      resp_q.push_back(r);
    end
    t_acc = cyc;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int idx;
    i_rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr = 32'd0;
    i_cmd_wdata = 32'd0;
    i_resp_ready = 1'b1;
    i_rule_rdata_valid = 1'b0;
    i_rule_rdata = 32'd0;

    // reset state
    tick(2);
    chk("rst_cmd_ready", o_cmd_ready, 1'b0);
    chk("rst_resp_valid", o_resp_valid, 1'b0);
    chk("rst_wren", o_rule_wren, 1'b0);
    chk("rst_rden", o_rule_rden, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_addr", o_rule_addr, 32'd0);
    chk("rst_wdata", o_rule_wdata, 32'd0);
    chk("rst_resp_data", o_resp_data, 32'd0);
    chk("rst_resp_status", o_resp_status, 2'b00);
    chk("rst_err_cnt", o_err_cnt, 16'd0);
    i_rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", o_cmd_ready, 1'b1);

    // single write
    send_cmd(1'b1, 32'h0000_0402, 32'h0000_0011, 1'b1, 32'h0000_0011, 2'b00, t);
    chk("wr_wren_t1", o_rule_wren, 1'b1);
    chk("wr_addr_t1", o_rule_addr, 32'h0000_0402);
    chk("wr_busy_t1", o_busy, 1'b1);
    chk("wr_resp_valid_t1", o_resp_valid, 1'b0);
    tick();
    chk("wr_wren_t2", o_rule_wren, 1'b0);
    chk("wr_resp_valid_t2", o_resp_valid, 1'b1);
    chk("wr_resp_status_t2", o_resp_status, 2'b00);
    chk("wr_resp_data_t2", o_resp_data, 32'h0000_0011);
    tick();
    chk("wr_cmd_ready_t3", o_cmd_ready, 1'b1);
    chk("wr_resp_valid_t3", o_resp_valid, 1'b0);

    // read with data 5 cycles after rden
    send_cmd(1'b0, 32'h0200_0300, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF, 2'b01, t);
    chk("rd_rden_t1", o_rule_rden, 1'b1);
    chk("rd_wdata_kept", o_rule_wdata, 32'h0000_0011);
    tick();
    chk("rd_rden_t2", o_rule_rden, 1'b0);
    tick(4);
    i_rule_rdata_valid = 1'b1;
    i_rule_rdata = 32'hDEAD_BEEF;
    chk("rd_resp_valid_pre", o_resp_valid, 1'b0);
    tick();
    i_rule_rdata_valid = 1'b0;
    chk("rd_resp_valid", o_resp_valid, 1'b1);
    chk("rd_resp_status", o_resp_status, 2'b01);
    chk("rd_resp_data", o_resp_data, 32'hDEAD_BEEF);
    tick();
    chk("rd_resp_valid_after", o_resp_valid, 1'b0);

    // read timeout
    send_cmd(1'b0, 32'h0100_0200, 32'd0, 1'b1, 32'd0, 2'b10, t);
    tick(8);
    chk("to_resp_valid_t9", o_resp_valid, 1'b0);
    chk("to_err_cnt_t9", o_err_cnt, 16'd0);
    tick();
    chk("to_resp_valid_t10", o_resp_valid, 1'b1);
    chk("to_resp_status", o_resp_status, 2'b10);
    chk("to_resp_data", o_resp_data, 32'd0);
    chk("to_err_cnt", o_err_cnt, 16'd1);
    tick();
    chk("to_idle_busy", o_busy, 1'b0);
    i_rule_rdata_valid = 1'b1;
    i_rule_rdata = 32'h0000_1234;
    tick(2);
    i_rule_rdata_valid = 1'b0;
    chk("stray_busy", o_busy, 1'b0);
    chk("stray_resp_valid", o_resp_valid, 1'b0);
    chk("stray_cmd_ready", o_cmd_ready, 1'b1);
    chk("stray_err_cnt", o_err_cnt, 16'd1);

    // response back-pressure
    i_resp_ready = 1'b0;
    send_cmd(1'b1, 32'h0100_0105, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001, 2'b00, t);
    tick();
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b1;
    i_cmd_addr  = 32'h0300_0207;
    i_cmd_wdata = 32'h0000_005A;
    for (int k = 0; k < 20; k++) begin
      chk("bp_resp_valid", o_resp_valid, 1'b1);
      chk("bp_resp_data", o_resp_data, 32'hA5A5_0001);
      chk("bp_resp_status", o_resp_status, 2'b00);
      chk("bp_cmd_ready", o_cmd_ready, 1'b0);
      tick();
    end
    i_resp_ready = 1'b1;
    tick();
    chk("bp_release_resp_valid", o_resp_valid, 1'b0);
    chk("bp_release_cmd_ready", o_cmd_ready, 1'b1);
    send_cmd(1'b1, 32'h0300_0207, 32'h0000_005A, 1'b1, 32'h0000_005A, 2'b00, t);
    chk("bp_second_wren", o_rule_wren, 1'b1);
    tick(3);

    // reset during RWAIT
    send_cmd(1'b0, 32'h0300_0001, 32'd0, 1'b0, 32'd0, 2'b00, t);
    tick(2);
    chk("rr_busy_rwait", o_busy, 1'b1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("rr_resp_valid", o_resp_valid, 1'b0);
    chk("rr_rden", o_rule_rden, 1'b0);
    chk("rr_err_cnt", o_err_cnt, 16'd0);
    chk("rr_busy", o_busy, 1'b0);
    last_wdata = 32'd0;
    tick();
    chk("rr_cmd_ready", o_cmd_ready, 1'b1);
    send_cmd(1'b1, 32'h0000_0010, 32'h0000_0077, 1'b1, 32'h0000_0077, 2'b00, t);
    chk("rr_wr_wren", o_rule_wren, 1'b1);
    tick();
    chk("rr_wr_resp_valid", o_resp_valid, 1'b1);
    tick(2);

    // four back-to-back writes, layers 0..3
    idx = wren_cyc.size();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h0000_0101 | (32'(i) << 24);
      send_cmd(1'b1, a, 32'h10 + 32'(i), 1'b1, 32'h10 + 32'(i), 2'b00, t);
    end
    tick(4);
    chk("b2b_wren_count", 32'(wren_cyc.size() - idx), 32'd4);
    if (wren_cyc.size() - idx == 4) begin
      for (int k = 1; k < 4; k++) begin
        chk("b2b_spacing", 32'(wren_cyc[idx+k] - wren_cyc[idx+k-1]), 32'd3);
      end
    end

    tick(3);
    chk("end_strobe_q_empty", 32'(strobe_q.size()), 32'd0);
    chk("end_resp_q_empty", 32'(resp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
